// File: rtl/updown_counter_if.sv
// ---------------------------------------------------------------------------
// updown_counter_if : control/status bundle for updown_counter
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface updown_counter_if #(
  parameter int N = 8
);
  logic [N-1:0] i_r;
  logic         i_l;
  logic         i_e;
  logic         i_up;
  logic [1:0]   i_mode;
  logic [N-1:0] i_max;
  logic [N-1:0] o_q;
  logic         o_tc;
  logic         o_zero;
  logic         o_done;

  modport master (
    output i_r, i_l, i_e, i_up, i_mode, i_max,
    input  o_q, o_tc, o_zero, o_done
  );

  modport slave (
    input  i_r, i_l, i_e, i_up, i_mode, i_max,
    output o_q, o_tc, o_zero, o_done
  );
endinterface

`default_nettype wire

// File: rtl/updown_counter.sv
// ---------------------------------------------------------------------------
// updown_counter : N-bit loadable up/down counter, wrap/saturate/one-shot
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module updown_counter #(
  parameter int N = 8
) (
  input  wire logic           clk,
  input  wire logic           rst,
  updown_counter_if.slave     bus
);

  localparam logic [1:0] c_MODE_WRAP    = 2'b00;
  localparam logic [1:0] c_MODE_SAT     = 2'b01;
  localparam logic [1:0] c_MODE_ONESHOT = 2'b10;

  logic [N-1:0] r_q;
  logic         r_tc;
  logic         r_done;

  logic [N-1:0] w_load_val;
  logic         w_above_max;
  logic         w_at_max;
  logic         w_at_zero;

  assign w_load_val  = (bus.i_r > bus.i_max) ? bus.i_max : bus.i_r;
  assign w_above_max = (r_q > bus.i_max);
  assign w_at_max    = (r_q == bus.i_max);
  assign w_at_zero   = (r_q == '0);

  // Boundaries are tested before stepping, so +1/-1 can never wrap silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      r_tc   <= 1'b0;
      r_done <= 1'b0;
    end else if (bus.i_l) begin
      r_q    <= w_load_val;
      r_tc   <= 1'b0;
      r_done <= 1'b0;
    end else if (bus.i_e && !r_done) begin
      if (w_above_max) begin
        r_q  <= bus.i_max;
        r_tc <= 1'b0;
      end else if (bus.i_up) begin
        if (w_at_max) begin
          r_tc <= 1'b1;
          case (bus.i_mode)
            c_MODE_SAT:     r_q    <= r_q;
            c_MODE_ONESHOT: r_done <= 1'b1;
            default:        r_q    <= '0;
          endcase
        end else begin
          r_q  <= r_q + 1'b1;
          r_tc <= 1'b0;
        end
      end else begin
        if (w_at_zero) begin
          r_tc <= 1'b1;
          case (bus.i_mode)
            c_MODE_SAT:     r_q    <= r_q;
            c_MODE_ONESHOT: r_done <= 1'b1;
            default:        r_q    <= bus.i_max;
          endcase
        end else begin
          r_q  <= r_q - 1'b1;
          r_tc <= 1'b0;
        end
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign bus.o_q    = r_q;
  assign bus.o_tc   = r_tc;
  assign bus.o_done = r_done;
  assign bus.o_zero = w_at_zero;

endmodule

`default_nettype wire

// File: tb/tb_updown_counter.sv
// ---------------------------------------------------------------------------
// tb_updown_counter : directed vectors plus per-cycle reference model check
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_updown_counter;

  localparam int N = 8;

  typedef struct packed {
    logic [N-1:0] q;
    logic         tc;
    logic         done;
  } mstate_t;

  logic clk = 1'b0;
  logic rst;

  updown_counter_if #(.N(N)) bus ();

  updown_counter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  mstate_t m;
  logic    m_valid = 1'b0;

  // Next state from the counting rules, in integer arithmetic on the range 0..Max.
  function automatic mstate_t model_next(mstate_t s, logic rs, logic ld, logic en,
                                         logic up, logic [1:0] mode,
                                         logic [N-1:0] mx, logic [N-1:0] rv);
    mstate_t n;
    int      target;
    n    = s;
    n.tc = 1'b0;
    if (rs) begin
      n.q    = '0;
      n.done = 1'b0;
    end else if (ld) begin
      n.q    = (int'(rv) < int'(mx)) ? rv : mx;
      n.done = 1'b0;
    end else if (en && !s.done) begin
      if (int'(s.q) > int'(mx)) begin
        n.q = mx;
      end else begin
        target = int'(s.q) + (up ? 1 : -1);
        if (target >= 0 && target <= int'(mx)) begin
          n.q = target[N-1:0];
        end else begin
          n.tc = 1'b1;
          if (mode == 2'd2) n.done = 1'b1;
          else if (mode != 2'd1) n.q = up ? '0 : mx;
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst || m_valid) begin
      m       <= model_next(m, rst, bus.i_l, bus.i_e, bus.i_up, bus.i_mode,
                            bus.i_max, bus.i_r);
      m_valid <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one edge, then compare every output against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("model_q",    32'(bus.o_q),    32'(m.q));
      chk("model_tc",   32'(bus.o_tc),   32'(m.tc));
      chk("model_done", 32'(bus.o_done), 32'(m.done));
      chk("model_zero", 32'(bus.o_zero), 32'(m.q == '0));
    end
  endtask

  task automatic expect3(input string nm, input logic [N-1:0] q, input logic tc,
                         input logic done);
    chk({nm, "_q"},    32'(bus.o_q),    32'(q));
    chk({nm, "_tc"},   32'(bus.o_tc),   32'(tc));
    chk({nm, "_done"}, 32'(bus.o_done), 32'(done));
  endtask

  logic [N-1:0] exp_q  [5];
  logic         exp_tc [5];
  logic         exp_dn [5];

  initial begin
    rst        = 1'b1;
    bus.i_l    = 1'b1;
    bus.i_r    = 8'h05;
    bus.i_e    = 1'b1;
    bus.i_up   = 1'b1;
    bus.i_mode = 2'b00;
    bus.i_max  = 8'd10;

    // Reset dominates load and enable
    tick(); expect3("rst1", 8'd0, 1'b0, 1'b0);
    tick(); expect3("rst2", 8'd0, 1'b0, 1'b0);
    rst = 1'b0; bus.i_l = 1'b0; bus.i_e = 1'b0;
    tick(); expect3("rst_rel", 8'd0, 1'b0, 1'b0);
    chk("rst_zero", 32'(bus.o_zero), 32'd1);

    // Load and clamp
    bus.i_l = 1'b1; bus.i_r = 8'd3;
    tick(); chk("load3", 32'(bus.o_q), 32'd3);
    bus.i_r = 8'd200;
    tick(); chk("load_clamp", 32'(bus.o_q), 32'd10);
    bus.i_r = 8'd4; bus.i_e = 1'b1;
    tick(); chk("load_over_en", 32'(bus.o_q), 32'd4);
    chk("load_nzero", 32'(bus.o_zero), 32'd0);

    // Wrap down
    bus.i_max = 8'd4; bus.i_mode = 2'b00; bus.i_up = 1'b0;
    bus.i_e = 1'b0; bus.i_r = 8'd2;
    tick(); chk("wrap_load", 32'(bus.o_q), 32'd2);
    bus.i_l = 1'b0; bus.i_e = 1'b1;
    exp_q  = '{8'd1, 8'd0, 8'd4, 8'd3, 8'd2};
    exp_tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick(); expect3($sformatf("wrap%0d", i), exp_q[i], exp_tc[i], 1'b0);
    end

    // Saturate up at the top of the N-bit range
    bus.i_max = 8'hFF; bus.i_mode = 2'b01; bus.i_up = 1'b1;
    bus.i_l = 1'b1; bus.i_e = 1'b0; bus.i_r = 8'hFE;
    tick(); chk("sat_load", 32'(bus.o_q), 32'hFE);
    bus.i_l = 1'b0; bus.i_e = 1'b1;
    exp_tc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tick(); expect3($sformatf("sat%0d", i), 8'hFF, exp_tc[i], 1'b0);
    end
    bus.i_e = 1'b0;
    tick(); expect3("sat_idle", 8'hFF, 1'b0, 1'b0);

    // One-shot down
    bus.i_max = 8'd9; bus.i_mode = 2'b10; bus.i_up = 1'b0;
    bus.i_l = 1'b1; bus.i_r = 8'd2;
    tick(); chk("os_load", 32'(bus.o_q), 32'd2);
    bus.i_l = 1'b0; bus.i_e = 1'b1;
    exp_q  = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
    exp_tc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    exp_dn = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      tick(); expect3($sformatf("os%0d", i), exp_q[i], exp_tc[i], exp_dn[i]);
    end
    bus.i_l = 1'b1; bus.i_r = 8'd5;
    tick(); expect3("os_rearm", 8'd5, 1'b0, 1'b0);
    bus.i_l = 1'b0;
    tick(); expect3("os_resume", 8'd4, 1'b0, 1'b0);

    // Max lowered while counting up
    bus.i_max = 8'd20; bus.i_mode = 2'b00; bus.i_up = 1'b1;
    bus.i_l = 1'b1; bus.i_r = 8'd15;
    tick(); chk("ml_load", 32'(bus.o_q), 32'd15);
    bus.i_l = 1'b0;
    tick(); expect3("ml_up", 8'd16, 1'b0, 1'b0);
    bus.i_max = 8'd8;
    tick(); expect3("ml_clamp", 8'd8, 1'b0, 1'b0);
    tick(); expect3("ml_wrap", 8'd0, 1'b1, 1'b0);
    tick(); expect3("ml_next", 8'd1, 1'b0, 1'b0);
    tick(); expect3("ml_next2", 8'd2, 1'b0, 1'b0);
    rst = 1'b1;
    tick(); expect3("ml_rst", 8'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Max of zero: every enabled edge is a boundary
    bus.i_max = 8'd0; bus.i_mode = 2'b00; bus.i_up = 1'b0;
    tick(); expect3("m0_wrap_dn", 8'd0, 1'b1, 1'b0);
    bus.i_up = 1'b1;
    tick(); expect3("m0_wrap_up", 8'd0, 1'b1, 1'b0);
    bus.i_mode = 2'b10; bus.i_l = 1'b1; bus.i_r = 8'd7;
    tick(); expect3("m0_load", 8'd0, 1'b0, 1'b0);
    bus.i_l = 1'b0;
    tick(); expect3("m0_os", 8'd0, 1'b1, 1'b1);
    tick(); expect3("m0_os_hold", 8'd0, 1'b0, 1'b1);

    // Mode 11 behaves as wrap
    bus.i_max = 8'd3; bus.i_mode = 2'b11; bus.i_up = 1'b1;
    bus.i_l = 1'b1; bus.i_r = 8'd3;
    tick(); expect3("m3_load", 8'd3, 1'b0, 1'b0);
    bus.i_l = 1'b0;
    tick(); expect3("m3_wrap", 8'd0, 1'b1, 1'b0);
    bus.i_up = 1'b0;
    tick(); expect3("m3_wrap_dn", 8'd3, 1'b1, 1'b0);
    tick(); expect3("m3_dn", 8'd2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/updown_counter.md
Name: updown_counter

Overview:
- Parametrised successor to the team's 8-bit loadable down counter.
- Synchronous N-bit up/down counter with:
  - parallel load
  - count enable
  - programmable upper limit (Max)
  - three boundary modes: wrap, saturate, one-shot
- Registered terminal-count pulse, zero flag and one-shot done flag.
- Used as a general timer/sequencer counter in the sequential-logic designs.

Parameters:
- N, 8, counter width in bits (N >= 2).

Ports:
- Clock  input  1  rising-edge clock; the only clock.
- Reset  input  1  synchronous, active-high reset.
- R  input  N  parallel load value.
- L  input  1  load strobe.
- E  input  1  count enable.
- Up  input  1  direction: 1 = count up, 0 = count down.
- Mode  input  2  boundary mode: 00 wrap, 01 saturate, 10 one-shot, 11 treated as 00.
- Max  input  N  upper count limit (inclusive); the count range is 0..Max.
- Q  output  N  registered count value.
- TC  output  1  registered terminal-count pulse.
- Zero  output  1  combinational, equals (Q == 0).
- Done  output  1  registered; one-shot run finished.

Behaviour:
- All state updates on the rising edge of Clock.
- Priority per edge: Reset > L > E. When E=0 and L=0, Q holds.
- Reset=1: Q=0, TC=0, Done=0. Inputs are ignored that cycle. Reset mid-count aborts immediately.
- Load (L=1):
  - Q <= min(R, Max), so a load above Max clamps to Max.
  - Done <= 0 (re-arms one-shot).
  - TC <= 0.
  - E is ignored in the same cycle.
- Enabled count (E=1, L=0, Done=0):
  - Up=1, Q < Max: Q <= Q+1, TC <= 0.
  - Up=1, Q == Max (boundary):
    - wrap: Q <= 0.
    - saturate: Q holds Max.
    - one-shot: Q holds Max, Done <= 1.
    - In all modes TC <= 1.
  - Up=0, Q > 0: Q <= Q-1, TC <= 0.
  - Up=0, Q == 0 (boundary):
    - wrap: Q <= Max.
    - saturate: Q holds 0.
    - one-shot: Q holds 0, Done <= 1.
    - In all modes TC <= 1.
  - Q > Max (Max lowered while counting), either direction: Q <= Max, TC <= 0. This is not a boundary event.
- Done=1: E is ignored, Q holds, TC <= 0. Only L or Reset clears Done.
- TC:
  - High for exactly one cycle after each boundary event.
  - Stays high on consecutive cycles while saturate mode keeps hitting the boundary with E=1.
  - Otherwise cleared on the next edge.
- Max == 0:
  - Every enabled count is a boundary event; Q stays 0 and TC=1 each enabled cycle.
  - In one-shot mode, Done sets on the first enabled edge.
- Up, Mode and Max are sampled each edge. Changing them mid-count takes effect on the next edge, with no glitch state.
- Arithmetic is unsigned N-bit. Internal +1/-1 is never allowed to overflow silently: the boundary is detected before the increment or decrement.
- Zero is combinational from Q only.

Test Plan:
- Reset check: Reset=1 for 2 edges, with L=1, R=8'h05 driven. Expect Q=0, TC=0, Done=0 after each edge. Release Reset: Q=0 still, Zero=1.
- Load and clamp, Max=8'd10: L=1 with R=3 gives Q=3. L=1 with R=200 gives Q=10. L=1 and E=1 together with R=4 gives Q=4, not 5.
- Wrap down, Max=8'd4, Mode=00, Up=0, load 2, then E=1 for 5 edges:
  - Q sequence 1,0,4,3,2.
  - TC=1 only in the cycle where Q=4 first appears.
- Saturate up, Max=8'hFF, Mode=01, Up=1, load 8'hFE, then E=1 for 4 edges:
  - Q sequence FE→FF,FF,FF,FF.
  - TC=0,1,1,1.
  - No overflow to 0.
- One-shot down, Max=8'd9, Mode=10, load 2, then E=1 for 5 edges:
  - Q sequence 1,0,0,0,0.
  - Done=1 from the 3rd edge onward.
  - TC=1 for exactly one cycle.
  - Then L=1 with R=5: Done=0, Q=5, and counting resumes.
- Max lowered mid-count: Max=20, Q=15, counting up. Set Max=8, keep E=1.
  - Next edge: Q=8, TC=0.
  - Following edge: TC=1, Q=0 (Mode=00).
  - Asserting Reset mid-sequence gives Q=0 on the next edge.
